// File: rtl/lcd_timed_controller.sv
// Avalon-MM slave for an HD44780-class character LCD: sequences RS/RW/data setup,
// the E pulse and hold in hardware, stalling the master until each access completes.
module lcd_timed_controller #(
  parameter int NIBBLE_MODE = 0,
  parameter int T_AS        = 2,
  parameter int T_PW        = 12,
  parameter int T_H         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int T_MAX = (T_AS > T_PW) ? ((T_AS > T_H) ? T_AS : T_H)
                                       : ((T_PW > T_H) ? T_PW : T_H);
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic          last_s;
  logic          rs_r, rs_s;
  logic          rw_r, rw_s;
  logic          nib_r, nib_s;
  logic [7:0]    wdata_r, wdata_s;
  logic          drive_r, drive_s;
  logic [7:0]    dout_r, dout_s;

  // Counter holds remaining cycles minus one, so zero marks the final cycle of a phase.
  function automatic logic [CW-1:0] dwell(input state_t s);
    case (s)
      S_SETUP: dwell = CW'(T_AS - 1);
      S_PULSE: dwell = CW'(T_PW - 1);
      S_HOLD:  dwell = CW'(T_H - 1);
      default: dwell = {CW{1'b0}};
    endcase
  endfunction

  assign last_s      = (cnt_r == {CW{1'b0}});
  assign waitrequest = (read | write) & (state_r != S_DONE);
  assign LCD_data    = drive_r ? dout_r : {8{1'bz}};

  // Next-state, access latch and bus-drive decode.
  always_comb begin
    state_s = state_r;
    rs_s    = rs_r;
    rw_s    = rw_r;
    nib_s   = nib_r;
    wdata_s = wdata_r;
    case (state_r)
      S_IDLE: begin
        if (read | write) begin
          state_s = S_SETUP;
          rs_s    = address[1];
          rw_s    = address[0] & ~write;
          wdata_s = writedata;
          nib_s   = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: state_s = last_s ? S_PULSE : S_SETUP;
      S_PULSE: state_s = last_s ? S_HOLD : S_PULSE;
      S_HOLD: begin
        if (!last_s) begin
          state_s = S_HOLD;
        end else if ((NIBBLE_MODE != 0) && !nib_r) begin
          state_s = S_SETUP;
          nib_s   = 1'b1;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    // The bus is only ever driven by a write-direction access in an active phase.
    drive_s = ((state_s == S_SETUP) || (state_s == S_PULSE) || (state_s == S_HOLD)) && !rw_s;
    if (NIBBLE_MODE != 0) begin
      dout_s = {(nib_s ? wdata_s[3:0] : wdata_s[7:4]), 4'h0};
    end else begin
      dout_s = wdata_s;
    end
  end

  // State, phase counter, latched access and registered LCD pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      rs_r    <= 1'b0;
      rw_r    <= 1'b0;
      nib_r   <= 1'b0;
      wdata_r <= 8'h00;
      drive_r <= 1'b0;
      dout_r  <= 8'h00;
      LCD_E   <= 1'b0;
      LCD_RS  <= 1'b0;
      LCD_RW  <= 1'b0;
    end else begin
      state_r <= state_s;
      rs_r    <= rs_s;
      rw_r    <= rw_s;
      nib_r   <= nib_s;
      wdata_r <= wdata_s;
      drive_r <= drive_s;
      dout_r  <= dout_s;
      LCD_E   <= (state_s == S_PULSE);
      LCD_RS  <= rs_s;
      LCD_RW  <= rw_s;
      if (state_s != state_r) begin
        cnt_r <= dwell(state_s);
      end else if (!last_s) begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

  // Read data is captured on the final E-high cycle, one nibble per pulse in 4-bit mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 8'h00;
    end else if ((state_r == S_PULSE) && last_s && rw_r) begin
      if (NIBBLE_MODE == 0) begin
        readdata <= LCD_data;
      end else if (nib_r) begin
        readdata[3:0] <= LCD_data[7:4];
      end else begin
        readdata[7:4] <= LCD_data[7:4];
      end
    end
  end

endmodule

// File: tb/tb_lcd_timed_controller.sv
// Bench for lcd_timed_controller: an 8-bit and a nibble instance, each checked cycle by
// cycle against a phase-timeline model of the LCD access, plus a simple LCD read model.
module tb_lcd_timed_controller;

  localparam int T_AS = 2;
  localparam int T_PW = 12;
  localparam int T_H  = 2;
  localparam int SEG  = T_AS + T_PW + T_H;
  localparam int MAXC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] address0 = 2'b00, address1 = 2'b00;
  logic       read0 = 1'b0, read1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic [7:0] mval0 = 8'h00, mval1 = 8'h00;
  wire  [7:0] rdata0, rdata1;
  wire        wait0, wait1, e0, e1, rs0, rs1, rw0, rw1;
  tri0  [7:0] bus0, bus1;

  // LCD side: the panel drives its bus only while E is high on a read.
  assign bus0 = (e0 && rw0) ? mval0 : 8'bz;
  assign bus1 = (e1 && rw1) ? mval1 : 8'bz;

  lcd_timed_controller #(.NIBBLE_MODE(0), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H)) dut0 (
    .clk(clk), .reset(reset), .address(address0), .read(read0), .write(write0),
    .writedata(wdata0), .readdata(rdata0), .waitrequest(wait0),
    .LCD_E(e0), .LCD_RS(rs0), .LCD_RW(rw0), .LCD_data(bus0));

  lcd_timed_controller #(.NIBBLE_MODE(1), .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H)) dut1 (
    .clk(clk), .reset(reset), .address(address1), .read(read1), .write(write1),
    .writedata(wdata1), .readdata(rdata1), .waitrequest(wait1),
    .LCD_E(e1), .LCD_RS(rs1), .LCD_RW(rw1), .LCD_data(bus1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  // Per-cycle signature: {waitrequest, E, RS, RW, bus[7:0]}
  logic [11:0] exp_sig [MAXC];
  logic [11:0] exp_msk [MAXC];
  logic [11:0] obs_sig [MAXC];
  int          n_exp;
  logic [7:0]  exp_rd, obs_rd;
  logic [7:0]  rd_model [2];
  int          first_hi, last_hi;

  // Byte the LCD model presents during pulse 'seg'; nibble mode uses [7:4] only.
  function automatic logic [7:0] mv(input bit nb, input int seg, input logic [7:0] mb,
                                    input logic [7:0] junk);
    if (nb) return (seg == 0) ? {mb[7:4], junk[3:0]} : {mb[3:0], junk[3:0]};
    return mb;
  endfunction

  // Reference timeline: request cycle, then per pulse T_AS setup / T_PW high / T_H hold, then one done cycle.
  task automatic build_exp(input bit nb, input bit wr, input logic [1:0] addr,
                           input logic [7:0] wd, input logic [7:0] mb,
                           input logic [7:0] junk, input logic [7:0] prev);
    int seg, w;
    bit rwb, e;
    logic [7:0] bus;
    rwb   = addr[0] & ~wr;
    n_exp = 2 + (nb ? 2 : 1) * SEG;
    for (int k = 0; k < n_exp; k++) begin
      if (k == 0 || k == n_exp - 1) begin
        exp_sig[k] = {(k == 0), 1'b0, 2'b00, 8'h00};
        exp_msk[k] = 12'hCFF;
      end else begin
        seg = (k - 1) / SEG;
        w   = (k - 1) % SEG;
        e   = (w >= T_AS) && (w < T_AS + T_PW);
        if (!rwb) bus = nb ? {((seg == 0) ? wd[7:4] : wd[3:0]), 4'h0} : wd;
        else      bus = e ? mv(nb, seg, mb, junk) : 8'h00;
        exp_sig[k] = {1'b1, e, addr[1], rwb, bus};
        exp_msk[k] = 12'hFFF;
      end
    end
    exp_rd = rwb ? mb : prev;
  endtask

  // Issues one request at a negedge, records n cycles of pins, drops the request after the done cycle.
  task automatic run_access(input int sel, input bit rd, input bit wr, input logic [1:0] addr,
                            input logic [7:0] wd, input logic [7:0] mb,
                            input logic [7:0] junk, input int n);
    logic [11:0] s;
    int seg;
    first_hi = -1;
    last_hi  = -1;
    if (sel == 0) begin address0 = addr; read0 = rd; write0 = wr; wdata0 = wd; end
    else          begin address1 = addr; read1 = rd; write1 = wr; wdata1 = wd; end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      seg = (k == 0) ? 0 : (k - 1) / SEG;
      if (sel == 0) mval0 = mv(1'b0, seg, mb, junk);
      else          mval1 = mv(1'b1, seg, mb, junk);
      #1;
      s = (sel == 0) ? {wait0, e0, rs0, rw0, bus0} : {wait1, e1, rs1, rw1, bus1};
      obs_sig[k] = s;
      if (s[10]) begin
        if (first_hi < 0) first_hi = cyc;
        last_hi = cyc;
      end
      if (k == n - 1) obs_rd = (sel == 0) ? rdata0 : rdata1;
    end
    @(negedge clk);
    if (sel == 0) begin read0 = 1'b0; write0 = 1'b0; end
    else          begin read1 = 1'b0; write1 = 1'b0; end
  endtask

  task automatic test_reset();
    logic [11:0] s;
    logic [7:0]  r;
    repeat (3) @(negedge clk);
    #1;
    for (int sel = 0; sel < 2; sel++) begin
      s = (sel == 0) ? {wait0, e0, rs0, rw0, bus0} : {wait1, e1, rs1, rw1, bus1};
      r = (sel == 0) ? rdata0 : rdata1;
      checks++;
      if (s !== 12'h000) begin errors++; $display("FAIL reset_pins dut%0d got %h exp 000", sel, s); end
      checks++;
      if (r !== 8'h00) begin errors++; $display("FAIL reset_readdata dut%0d got %h exp 00", sel, r); end
    end
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    reset = 1'b0;
  endtask

  task automatic test_write8();
    @(negedge clk);
    build_exp(1'b0, 1'b1, 2'b10, 8'h41, 8'h00, 8'h00, rd_model[0]);
    run_access(0, 1'b0, 1'b1, 2'b10, 8'h41, 8'h00, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL write8 cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    rd_model[0] = exp_rd;
  endtask

  task automatic test_read8();
    @(negedge clk);
    build_exp(1'b0, 1'b0, 2'b01, 8'h5A, 8'h80, 8'h00, rd_model[0]);
    run_access(0, 1'b1, 1'b0, 2'b01, 8'h5A, 8'h80, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL read8 cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL read8_data got %h exp %h", obs_rd, exp_rd); end
    rd_model[0] = exp_rd;
  endtask

  task automatic test_nibble_write();
    @(negedge clk);
    build_exp(1'b1, 1'b1, 2'b00, 8'h3C, 8'h00, 8'h00, rd_model[1]);
    run_access(1, 1'b0, 1'b1, 2'b00, 8'h3C, 8'h00, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL nib_write cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    rd_model[1] = exp_rd;
  endtask

  task automatic test_nibble_read();
    @(negedge clk);
    build_exp(1'b1, 1'b0, 2'b11, 8'hFF, 8'hA5, 8'h09, rd_model[1]);
    run_access(1, 1'b1, 1'b0, 2'b11, 8'hFF, 8'hA5, 8'h09, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL nib_read cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL nib_read_data got %h exp %h", obs_rd, exp_rd); end
    rd_model[1] = exp_rd;
  endtask

  task automatic test_back_to_back();
    int last_a, gap;
    @(negedge clk);
    build_exp(1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 8'h00, rd_model[0]);
    run_access(0, 1'b0, 1'b1, 2'b10, 8'h01, 8'h00, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL b2b_first cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    last_a = last_hi;
    // Second access asserts read and write together on a read address: must act as a write.
    build_exp(1'b0, 1'b1, 2'b11, 8'h02, 8'hEE, 8'h00, exp_rd);
    run_access(0, 1'b1, 1'b1, 2'b11, 8'h02, 8'hEE, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL b2b_second cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
    gap = first_hi - last_a - 1;
    checks++;
    if (gap !== T_H + 2 + T_AS) begin
      errors++; $display("FAIL b2b_gap got %0d exp %0d", gap, T_H + 2 + T_AS);
    end
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL b2b_readdata got %h exp %h", obs_rd, exp_rd); end
    rd_model[0] = exp_rd;
  endtask

  task automatic test_reset_mid();
    logic [11:0] s;
    @(negedge clk);
    address0 = 2'b10; write0 = 1'b1; wdata0 = 8'hA5;
    // Cycle T_AS+5 after the request is the fifth E-high cycle.
    for (int k = 0; k <= T_AS + 5; k++) begin
      if (k > 0) @(negedge clk);
    end
    #1;
    checks++;
    if (e0 !== 1'b1) begin errors++; $display("FAIL rstmid_pulse got %b exp 1", e0); end
    reset = 1'b1; write0 = 1'b0;
    @(negedge clk);
    #1;
    s = {wait0, e0, 2'b00, bus0};
    checks++;
    if (s !== 12'h000) begin errors++; $display("FAIL rstmid_pins got %h exp 000", s); end
    checks++;
    if (rdata0 !== 8'h00) begin errors++; $display("FAIL rstmid_readdata got %h exp 00", rdata0); end
    reset = 1'b0;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    // A fresh access with full latency shows the FSM restarted from idle.
    @(negedge clk);
    build_exp(1'b0, 1'b1, 2'b00, 8'h5A, 8'h00, 8'h00, rd_model[0]);
    run_access(0, 1'b0, 1'b1, 2'b00, 8'h5A, 8'h00, 8'h00, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      checks++;
      if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
        errors++; $display("FAIL rstmid_after cyc%0d got %h exp %h", k, obs_sig[k] & exp_msk[k], exp_sig[k]);
      end
    end
  endtask

  task automatic test_random();
    int sel, op;
    bit rd, wr;
    logic [1:0] addr;
    logic [7:0] wd, mb, junk;
    @(negedge clk);
    for (int t = 0; t < 24; t++) begin
      sel  = $urandom_range(0, 1);
      op   = $urandom_range(0, 2);
      rd   = (op != 1);
      wr   = (op != 0);
      addr = 2'($urandom);
      wd   = 8'($urandom);
      mb   = 8'($urandom);
      junk = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      build_exp(sel == 1, wr, addr, wd, mb, junk, rd_model[sel]);
      run_access(sel, rd, wr, addr, wd, mb, junk, n_exp);
      for (int k = 0; k < n_exp; k++) begin
        checks++;
        if ((obs_sig[k] & exp_msk[k]) !== exp_sig[k]) begin
          errors++;
          $display("FAIL random t%0d dut%0d cyc%0d got %h exp %h", t, sel, k, obs_sig[k] & exp_msk[k], exp_sig[k]);
        end
      end
      checks++;
      if (obs_rd !== exp_rd) begin
        errors++; $display("FAIL random_data t%0d dut%0d got %h exp %h", t, sel, obs_rd, exp_rd);
      end
      rd_model[sel] = exp_rd;
    end
  endtask

  initial begin
    test_reset();
    test_write8();
    test_read8();
    test_nibble_write();
    test_nibble_read();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_timed_controller.md
Name: lcd_timed_controller

Overview:
- Avalon-MM slave driving an HD44780-class character LCD.
- Generates the controller's E-strobe timing in hardware (setup, pulse width, hold) and stalls the bus with waitrequest until each access completes.
- Supports an 8-bit or 4-bit (nibble) LCD bus, selected by parameter.
- Sits between the Nios II data master and the board LCD header; software no longer needs busy-wait delays to meet bus timing.

Parameters:
- NIBBLE_MODE, 0, 0 = 8-bit LCD bus; 1 = 4-bit bus on LCD_data[7:4], two E pulses per access, high nibble first.
- T_AS, 2, clk cycles RS/RW/data are stable before E rises (min 1).
- T_PW, 12, clk cycles E is held high (min 1).
- T_H, 2, clk cycles RS/RW/data are held after E falls (min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  bit0 = RW (1 read), bit1 = RS (1 data register).
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  8  byte to LCD.
- readdata  out  8  byte from LCD, valid in the DONE cycle.
- waitrequest  out  1  Avalon stall.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  read/not-write.
- LCD_data  inout  8  LCD data bus, tri-stated when not driving.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state IDLE; LCD_E=0, LCD_RS=0, LCD_RW=0; LCD_data released (Z); readdata=0x00; all counters 0.
- waitrequest = (read|write) & (state!=DONE), combinational. It is 0 whenever no request is present.
- IDLE:
  - On read|write, latch rs=address[1], rw=address[0], wdata=writedata, nib=0, then go to SETUP.
  - Accesses issued with write=1 force rw=0 (write wins if read and write are both asserted).
  - Address and writedata changes after the latch are ignored until DONE.
- SETUP (T_AS cycles):
  - LCD_RS=rs, LCD_RW=rw, LCD_E=0.
  - If rw=0, drive LCD_data: 8-bit mode drives wdata; nibble mode drives {wdata[7:4] or wdata[3:0], 4'b0} according to nib.
- PULSE (T_PW cycles): LCD_E=1, RS/RW/data unchanged.
  - On the last PULSE cycle with rw=1, sample LCD_data.
  - 8-bit mode: readdata <= LCD_data.
  - Nibble mode: nib=0 loads readdata[7:4]; nib=1 loads readdata[3:0], both from LCD_data[7:4].
- HOLD (T_H cycles): LCD_E=0, RS/RW/data still held.
  - At the end of HOLD: in nibble mode with nib=0, set nib=1 and go to SETUP; otherwise go to DONE.
- DONE (1 cycle):
  - waitrequest=0, so the master completes.
  - LCD_data released, LCD_E=0; RS/RW may keep their last value.
  - Next state is IDLE.
- Latency from request to completion edge: 8-bit mode is 2+T_AS+T_PW+T_H cycles (default 18); nibble mode adds T_AS+T_PW+T_H (default 34).
- Back-to-back requests: IDLE takes at least one cycle between accesses, so there is always at least T_H+2 cycles of E low between pulses.
- Single cycle counter sized for max(T_AS,T_PW,T_H); it reloads on each state entry. E never glitches: it is registered and high only in PULSE.
- Bus contention: LCD_data is driven only while the latched rw=0 and the state is SETUP, PULSE or HOLD. It is never driven during rw=1 accesses.
- Reset mid-access: the next edge forces IDLE, LCD_E=0 and releases the bus. The pending request is not completed; the master must reissue it.
- A request deasserted mid-access (protocol violation): the FSM still runs to DONE, then returns to IDLE.

Test Plan:
- Defaults, write address=2'b10, writedata=0x41 -> RS=1, RW=0, data 0x41 on bus; E high for exactly 12 cycles starting 3 cycles after the request; waitrequest low on cycle 18 only.
- Read address=2'b01, LCD model drives 0x80 while E is high -> RW=1, bus never driven by DUT, readdata=0x80 in the DONE cycle, latency 18.
- NIBBLE_MODE=1, write 0x3C to address 2'b00 -> two E pulses carrying 0x30 then 0xC0 on LCD_data, latency 34.
- NIBBLE_MODE=1, read with model returning 0xA then 0x5 on [7:4] -> readdata=0xA5.
- Back-to-back writes 0x01 then 0x02 with read and write asserted together on the second -> two E pulses separated by at least 4 low cycles; second access treated as write.
- Assert reset on the 5th PULSE cycle -> next edge LCD_E=0, LCD_data=Z, waitrequest=0 with no request present, FSM in IDLE.
